sntc_ldpc_enc_serializer: RTL and testbench

Downstream stage of the LDPC encoder wrapper. It captures each full NN-bit encoded codeword, plus its syndrome-zero flag from the syndrome wrapper, and streams it out as OW-bit beats over a valid/ready interface toward the modulator/packer. A one-codeword shadow buffer lets the encoder hand over the next codeword while the current one is streaming. With the shadow used this way, back-to-back codewords stream with no idle beat between them.

---
 rtl/sntc_ldpc_enc_serializer_if.sv | 28 ++
 rtl/sntc_ldpc_enc_serializer.sv | 130 +++++++++++++
 tb/tb_sntc_ldpc_enc_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sntc_ldpc_enc_serializer_if.sv
// Codeword-in / beat-out bundle for the LDPC encoder serializer.
// The encoder-facing side uses master; the serializer uses slave.
interface sntc_ldpc_enc_serializer_if #(
    parameter int NN = 208,
    parameter int OW = 16
);
    logic [NN-1:0] cw_in;
    logic          cw_in_vld;
    logic          cw_in_chk;
    logic          cw_in_rdy;
    logic [OW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic          dout_sop;
    logic          dout_eop;
    logic          busy;
    logic [15:0]   drop_cnt;

    modport master (
        output cw_in, cw_in_vld, cw_in_chk, dout_rdy,
        input  cw_in_rdy, dout, dout_vld, dout_sop, dout_eop, busy, drop_cnt
    );

    modport slave (
        input  cw_in, cw_in_vld, cw_in_chk, dout_rdy,
        output cw_in_rdy, dout, dout_vld, dout_sop, dout_eop, busy, drop_cnt
    );
endinterface

// File: rtl/sntc_ldpc_enc_serializer.sv
// Captures NN-bit codewords (with a one-word shadow buffer) and streams them as OW-bit beats.
// Optional feature macro SNTC_ENC_CHK_EN: discard words whose syndrome flag is 0 and count them.
module sntc_ldpc_enc_serializer #(
    parameter int NN    = 'h000d0,
    parameter int MM    = 'h000a8,
    parameter int OW    = 16,
    parameter int BEATS = (NN + OW - 1) / OW,
    parameter int BW    = $clog2(BEATS + 1)
) (
    input  logic                          clk,
    input  logic                          clr,
    sntc_ldpc_enc_serializer_if.slave     bus
);
    // SR is padded to a whole number of beats so the last beat shifts out with zero fill.
    localparam int PW = BEATS * OW;

    if (OW < 1 || OW > NN || MM >= NN) begin : g_cfg_err
        $error("sntc_ldpc_enc_serializer: illegal NN/MM/OW combination");
    end

    typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_sr;
    logic [BW-1:0]   r_bcnt;
    logic [NN-1:0]   r_sh;
    logic            r_sh_full;
    logic            r_cw_in_rdy;

    state_t          w_state_next;
    logic [PW-1:0]   w_sr_next;
    logic [BW-1:0]   w_bcnt_next;
    logic [NN-1:0]   w_sh_next;
    logic            w_sh_full_next;

    logic            w_in_hs;
    logic            w_keep;
    logic            w_out_hs;
    logic            w_last;
    logic            w_eop_hs;
    logic            w_sr_free;

    assign w_in_hs   = bus.cw_in_vld & r_cw_in_rdy;
    assign w_out_hs  = (r_state == S_SEND) & bus.dout_rdy;
    assign w_last    = (r_bcnt == BW'(BEATS - 1));
    assign w_eop_hs  = w_out_hs & w_last;
    assign w_sr_free = (r_state == S_IDLE) | w_eop_hs;

`ifdef SNTC_ENC_CHK_EN
    logic [15:0] r_drop_cnt;

    assign w_keep = w_in_hs & bus.cw_in_chk;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_drop_cnt <= '0;
        end else if (w_in_hs && !bus.cw_in_chk && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    logic w_unused_chk;

    assign w_keep       = w_in_hs;
    assign w_unused_chk = bus.cw_in_chk;
    assign bus.drop_cnt = '0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_bcnt_next    = r_bcnt;
        w_sh_next      = r_sh;
        w_sh_full_next = r_sh_full;

        if (w_out_hs) begin
            w_sr_next   = r_sr >> OW;
            w_bcnt_next = r_bcnt + BW'(1);
        end

        // On eop the shadow word takes over SR so the next sop follows without a gap.
        if (w_eop_hs) begin
            w_bcnt_next  = '0;
            w_state_next = S_IDLE;
            if (r_sh_full) begin
                w_sr_next      = PW'(r_sh);
                w_sh_full_next = 1'b0;
                w_state_next   = S_SEND;
            end
        end

        if (w_keep) begin
            if (w_sr_free && !r_sh_full) begin
                w_sr_next    = PW'(bus.cw_in);
                w_bcnt_next  = '0;
                w_state_next = S_SEND;
            end else begin
                w_sh_next      = bus.cw_in;
                w_sh_full_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_bcnt      <= '0;
            r_sh        <= '0;
            r_sh_full   <= 1'b0;
            r_cw_in_rdy <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_bcnt      <= w_bcnt_next;
            r_sh        <= w_sh_next;
            r_sh_full   <= w_sh_full_next;
            r_cw_in_rdy <= !w_sh_full_next;
        end
    end

    assign bus.cw_in_rdy = r_cw_in_rdy;
    assign bus.dout_vld  = (r_state == S_SEND);
    assign bus.dout      = bus.dout_vld ? r_sr[OW-1:0] : '0;
    assign bus.dout_sop  = bus.dout_vld & (r_bcnt == '0);
    assign bus.dout_eop  = bus.dout_vld & w_last;
    assign bus.busy      = (r_state == S_SEND) | r_sh_full;
endmodule

// File: tb/tb_sntc_ldpc_enc_serializer.sv
// Self-checking bench: a word-queue reference model predicts every beat, flag and ready level.
module tb_sntc_ldpc_enc_serializer;
    localparam int NN  = 208;
    localparam int MM  = 168;
    localparam int OWA = 16;
    localparam int OWB = 24;
    localparam int BA  = (NN + OWA - 1) / OWA;
    localparam int BB  = (NN + OWB - 1) / OWB;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    sntc_ldpc_enc_serializer_if #(.NN(NN), .OW(OWA)) bus_a ();
    sntc_ldpc_enc_serializer_if #(.NN(NN), .OW(OWB)) bus_b ();

    sntc_ldpc_enc_serializer #(.NN(NN), .MM(MM), .OW(OWA)) u_dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a.slave)
    );

    sntc_ldpc_enc_serializer #(.NN(NN), .MM(MM), .OW(OWB)) u_dut_b (
        .clk (clk),
        .clr (clr),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted but not yet fully emitted, and the beat index of the head word.
    logic [NN-1:0] wq[$];
    int bidx      = 0;
    int exp_drop  = 0;
    int words_out = 0;
    int rdy_mode  = 0;
    bit last_in_hs = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_of(input logic [NN-1:0] cw, input int i, input int ow);
        logic [NN+31:0] t;
        t = {32'b0, cw} >> (i * ow);
        return t[31:0] & ((32'd1 << ow) - 32'd1);
    endfunction

    function automatic logic [NN-1:0] rand_word();
        logic [NN-1:0] w;
        w = '0;
        for (int k = 0; k < 7; k++) w = (w << 32) | NN'($urandom());
        return w;
    endfunction

    // One clock of DUT A: compare at negedge, update the model, step past the edge.
    task automatic cyc();
        bit keep;
        @(negedge clk);
        check("a_vld",  bus_a.dout_vld,  wq.size() != 0);
        check("a_rdy",  bus_a.cw_in_rdy, wq.size() < 2);
        check("a_busy", bus_a.busy,      wq.size() != 0);
        check("a_drop", bus_a.drop_cnt,  exp_drop);
        if (wq.size() != 0) begin
            check("a_dout", bus_a.dout,     beat_of(wq[0], bidx, OWA));
            check("a_sop",  bus_a.dout_sop, bidx == 0);
            check("a_eop",  bus_a.dout_eop, bidx == BA - 1);
            if (bus_a.dout_rdy) begin
                if (bidx == BA - 1) begin
                    void'(wq.pop_front());
                    bidx = 0;
                    words_out++;
                end else begin
                    bidx++;
                end
            end
        end
        last_in_hs = bus_a.cw_in_vld && bus_a.cw_in_rdy;
        if (last_in_hs) begin
`ifdef SNTC_ENC_CHK_EN
            keep = bus_a.cw_in_chk;
            if (!keep && exp_drop != 'hFFFF) exp_drop++;
`else
            keep = 1'b1;
`endif
            if (keep) wq.push_back(bus_a.cw_in);
        end
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus_a.dout_rdy = 1'b1;
            1:       bus_a.dout_rdy = ~bus_a.dout_rdy;
            default: bus_a.dout_rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [NN-1:0] w, input logic c);
        bus_a.cw_in     = w;
        bus_a.cw_in_chk = c;
        bus_a.cw_in_vld = 1'b1;
        for (int t = 0; t < 300; t++) begin
            cyc();
            if (last_in_hs) break;
        end
        bus_a.cw_in_vld = 1'b0;
        check("send_timeout", last_in_hs, 1'b1);
        $display("send word=%0h chk=%0d", w, c);
    endtask

    task automatic drain();
        for (int t = 0; t < 800 && wq.size() != 0; t++) cyc();
        check("drain_timeout", wq.size() == 0, 1'b1);
        cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_vld"},  bus_a.dout_vld,  1'b0);
        check({tag, "_a_sop"},  bus_a.dout_sop,  1'b0);
        check({tag, "_a_eop"},  bus_a.dout_eop,  1'b0);
        check({tag, "_a_dout"}, bus_a.dout,      '0);
        check({tag, "_a_rdy"},  bus_a.cw_in_rdy, 1'b0);
        check({tag, "_a_busy"}, bus_a.busy,      1'b0);
        check({tag, "_a_drop"}, bus_a.drop_cnt,  '0);
        check({tag, "_b_vld"},  bus_b.dout_vld,  1'b0);
        check({tag, "_b_rdy"},  bus_b.cw_in_rdy, 1'b0);
        check({tag, "_b_dout"}, bus_b.dout,      '0);
    endtask

    initial begin
        int base;
        logic [NN-1:0] ones;
        bus_a.cw_in = '0; bus_a.cw_in_vld = 1'b0; bus_a.cw_in_chk = 1'b1; bus_a.dout_rdy = 1'b1;
        bus_b.cw_in = '0; bus_b.cw_in_vld = 1'b0; bus_b.cw_in_chk = 1'b1; bus_b.dout_rdy = 1'b1;

        // Reset held for three cycles, then ready on the first cycle after release.
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("rel_a_rdy", bus_a.cw_in_rdy, 1'b1);
        check("rel_b_rdy", bus_b.cw_in_rdy, 1'b1);
        $display("reset released");

        // Single word with only bit 0 set.
        rdy_mode = 0;
        send(NN'(1), 1'b1);
        drain();
        check("single_words", words_out, 1);

        // Padding on the 24-bit instance: all-ones word, 9 beats, last one 16 bits wide.
        ones = '1;
        bus_b.cw_in = ones;
        bus_b.cw_in_vld = 1'b1;
        @(posedge clk);
        #1;
        bus_b.cw_in_vld = 1'b0;
        for (int i = 0; i < BB; i++) begin
            @(negedge clk);
            check("b_vld",  bus_b.dout_vld, 1'b1);
            check("b_dout", bus_b.dout,     beat_of(ones, i, OWB));
            check("b_sop",  bus_b.dout_sop, i == 0);
            check("b_eop",  bus_b.dout_eop, i == BB - 1);
            $display("pad beat %0d dout=%0h", i, bus_b.dout);
        end
        @(negedge clk);
        check("b_idle", bus_b.dout_vld, 1'b0);
        check("b_last_pad", beat_of(ones, BB - 1, OWB), 32'h0000FFFF);
        @(posedge clk);
        #1;

        // Back-to-back words with alternating backpressure.
        base = words_out;
        rdy_mode = 1;
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b1);
        drain();
        check("b2b_words", words_out - base, 2);

        // Randomized words, gaps, syndrome flags and backpressure.
        base = words_out;
        rdy_mode = 2;
        for (int n = 0; n < 8; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc();
            send(rand_word(), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Drop handling: flags 1, 0, 1.
        rdy_mode = 0;
        base = words_out;
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b0);
        send(rand_word(), 1'b1);
        drain();
`ifdef SNTC_ENC_CHK_EN
        check("drop_words", words_out - base, 2);
`else
        check("drop_words", words_out - base, 3);
        check("drop_cnt_zero", bus_a.drop_cnt, '0);
`endif

        // Reset while beat 5 is on the bus: stream abandoned, no eop.
        send(rand_word(), 1'b1);
        for (int t = 0; t < 50 && bidx != 5; t++) cyc();
        check("mid_reach", bidx, 5);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid");
        wq.delete();
        bidx = 0;
        exp_drop = 0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rel_rdy", bus_a.cw_in_rdy, 1'b1);
        base = words_out;
        send(rand_word(), 1'b1);
        drain();
        check("mid_after_words", words_out - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
